// File: rtl/fpmul_iter_param.sv
// Parametrised multi-cycle floating-point multiplier with a Start/Done handshake.
// Significands are multiplied R bits per cycle; denormal inputs are flushed to zero.
module fpmul_iter_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int R     = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic [1:0]           RM,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    output logic                 Busy,
    output logic                 Done,
    output logic [EXP_W+MAN_W:0] P,
    output logic                 OF,
    output logic                 UF,
    output logic                 NaNF,
    output logic                 InfF,
    output logic                 DNF,
    output logic                 ZF,
    output logic                 NX
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int N    = (SW + R - 1) / R;
    localparam int CW   = $clog2(N + 1);
    localparam int XW   = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      rm_q, rm_d;
    logic            sign_q, sign_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [SW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [XW-1:0]   exp_q, exp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    p_q, p_d;
    logic            of_q, of_d, uf_q, uf_d, nan_q, nan_d, inf_q, inf_d;
    logic            dn_q, dn_d, z_q, z_d, nx_q, nx_d;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, a_den, a_inf, a_nan;
    logic             b_zero, b_den, b_inf, b_nan;
    logic             prod_sign;

    assign a_exp     = a_q[W-2 -: EXP_W];
    assign b_exp     = b_q[W-2 -: EXP_W];
    assign a_frac    = a_q[MAN_W-1:0];
    assign b_frac    = b_q[MAN_W-1:0];
    assign a_zero    = (a_exp == '0);
    assign b_zero    = (b_exp == '0);
    assign a_den     = a_zero & (|a_frac);
    assign b_den     = b_zero & (|b_frac);
    assign a_inf     = (&a_exp) & ~(|a_frac);
    assign b_inf     = (&b_exp) & ~(|b_frac);
    assign a_nan     = (&a_exp) & (|a_frac);
    assign b_nan     = (&b_exp) & (|b_frac);
    assign prod_sign = a_q[W-1] ^ b_q[W-1];

    // After NORM the hidden bit sits in acc_q[PW-1]; below it the kept fraction, then G, R, sticky.
    logic [MAN_W-1:0] frac_keep;
    logic             g_bit, r_bit, s_bit, lsb_bit, inexact, round_up, to_inf;
    logic [MAN_W:0]   frac_sum;
    logic [XW-1:0]    exp_r;
    logic             ovf, unf;

    assign frac_keep = acc_q[PW-2 -: MAN_W];
    assign lsb_bit   = acc_q[PW-SW];
    assign g_bit     = acc_q[PW-1-SW];
    assign r_bit     = acc_q[PW-2-SW];
    assign s_bit     = |acc_q[PW-3-SW:0];
    assign inexact   = g_bit | r_bit | s_bit;

    always_comb begin
        round_up = 1'b0;
        case (rm_q)
            2'b00:   round_up = g_bit & (r_bit | s_bit | lsb_bit);
            2'b01:   round_up = 1'b0;
            2'b10:   round_up = inexact & ~sign_q;
            default: round_up = inexact & sign_q;
        endcase
    end

    assign frac_sum = {1'b0, frac_keep} + (MAN_W+1)'(round_up);
    assign exp_r    = exp_q + XW'(frac_sum[MAN_W]);
    assign ovf      = ~exp_r[XW-1] & (exp_r >= XW'(EMAX));
    assign unf      = exp_r[XW-1] | (exp_r == '0);
    assign to_inf   = (rm_q == 2'b00) | ((rm_q == 2'b10) & ~sign_q) | ((rm_q == 2'b11) & sign_q);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            dn_q     <= 1'b0;
            z_q      <= 1'b0;
            nx_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            of_q     <= of_d;
            uf_q     <= uf_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            dn_q     <= dn_d;
            z_q      <= z_d;
            nx_q     <= nx_d;
        end
    end

    logic [PW-1:0] term;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        of_d     = of_q;
        uf_d     = uf_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        dn_d     = dn_q;
        z_d      = z_q;
        nx_d     = nx_q;
        term     = '0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    rm_d    = RM;
                    p_d     = '0;
                    of_d    = 1'b0;
                    uf_d    = 1'b0;
                    nan_d   = 1'b0;
                    inf_d   = 1'b0;
                    dn_d    = 1'b0;
                    z_d     = 1'b0;
                    nx_d    = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d = prod_sign;
                dn_d   = a_den | b_den;
                if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
                    p_d     = '1;
                    nan_d   = 1'b1;
                    state_d = S_DONE;
                end else if (a_inf | b_inf) begin
                    p_d     = {prod_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    inf_d   = 1'b1;
                    state_d = S_DONE;
                end else if (a_zero | b_zero) begin
                    p_d     = {prod_sign, {(W-1){1'b0}}};
                    z_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    mcand_d  = {{SW{1'b0}}, 1'b1, a_frac};
                    mplier_d = {1'b1, b_frac};
                    acc_d    = '0;
                    exp_d    = XW'(a_exp) + XW'(b_exp) - XW'(BIAS);
                    cnt_d    = '0;
                    state_d  = S_MULT;
                end
            end
            S_MULT: begin
                for (int j = 0; j < R; j++) begin
                    if (mplier_q[j]) begin
                        term = term + (mcand_q << j);
                    end
                end
                acc_d    = acc_q + term;
                mcand_d  = mcand_q << R;
                mplier_d = mplier_q >> R;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Left-justify so the hidden bit always lands in the accumulator MSB.
                if (acc_q[PW-1]) begin
                    exp_d = exp_q + 1'b1;
                end else begin
                    acc_d = acc_q << 1;
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (ovf) begin
                    p_d   = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                   : {sign_q, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
                    inf_d = to_inf;
                    of_d  = 1'b1;
                    nx_d  = 1'b1;
                end else if (unf) begin
                    p_d  = {sign_q, {(W-1){1'b0}}};
                    uf_d = 1'b1;
                    z_d  = 1'b1;
                    nx_d = 1'b1;
                end else begin
                    p_d  = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    nx_d = inexact;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = (state_q == S_DONE);
    assign P    = p_q;
    assign OF   = of_q;
    assign UF   = uf_q;
    assign NaNF = nan_q;
    assign InfF = inf_q;
    assign DNF  = dn_q;
    assign ZF   = z_q;
    assign NX   = nx_q;

endmodule

// File: tb/tb_fpmul_iter_param.sv
// Bench for fpmul_iter_param: default single-precision instance plus a 16-bit R=2 instance,
// both checked against an arithmetic reference model of the multiplier.
module tb_fpmul_iter_param;

    localparam int N32 = 24;
    localparam int N16 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32_n, start32, busy32, done32;
    logic [1:0]  rm32;
    logic [31:0] a32, b32, p32;
    logic        of32, uf32, nan32, inf32, dn32, z32, nx32;

    logic        rst16_n, start16, busy16, done16;
    logic [1:0]  rm16;
    logic [15:0] a16, b16, p16;
    logic        of16, uf16, nan16, inf16, dn16, z16, nx16;

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    fpmul_iter_param dut32 (
        .Clk(clk), .Rst_n(rst32_n), .Start(start32), .RM(rm32), .A(a32), .B(b32),
        .Busy(busy32), .Done(done32), .P(p32), .OF(of32), .UF(uf32), .NaNF(nan32),
        .InfF(inf32), .DNF(dn32), .ZF(z32), .NX(nx32)
    );

    fpmul_iter_param #(.EXP_W(5), .MAN_W(10), .R(2)) dut16 (
        .Clk(clk), .Rst_n(rst16_n), .Start(start16), .RM(rm16), .A(a16), .B(b16),
        .Busy(busy16), .Done(done16), .P(p16), .OF(of16), .UF(uf16), .NaNF(nan16),
        .InfF(inf16), .DNF(dn16), .ZF(z16), .NX(nx16)
    );

    // flags packed as {OF, UF, NaNF, InfF, DNF, ZF, NX}
    typedef struct packed {
        logic [31:0] p;
        logic [6:0]  f;
        logic        special;
    } ref_res_t;

    function automatic ref_res_t ref_mul(input int ew, input int mw, input longint a,
                                         input longint b, input int rm);
        ref_res_t r;
        longint one, emax, bias, mask, ea, eb, fa, fb, prod, kept, rem, half, e, res;
        int     shift;
        bit     sign, az, bz, ad, bd, ai, bi, an, bn, up, to_inf;
        r     = '0;
        one   = 1;
        emax  = (one << ew) - 1;
        bias  = (one << (ew - 1)) - 1;
        mask  = (one << mw) - 1;
        sign  = bit'(((a >> (ew + mw)) ^ (b >> (ew + mw))) & 1);
        ea    = (a >> mw) & emax;
        eb    = (b >> mw) & emax;
        fa    = a & mask;
        fb    = b & mask;
        az    = (ea == 0);
        bz    = (eb == 0);
        ad    = az && (fa != 0);
        bd    = bz && (fb != 0);
        ai    = (ea == emax) && (fa == 0);
        bi    = (eb == emax) && (fb == 0);
        an    = (ea == emax) && (fa != 0);
        bn    = (eb == emax) && (fb != 0);
        r.f[2] = ad | bd;
        res   = longint'(sign) << (ew + mw);
        if (an || bn || (ai && bz) || (bi && az)) begin
            r.special = 1'b1;
            r.f[4]    = 1'b1;
            res       = (one << (1 + ew + mw)) - 1;
        end else if (ai || bi) begin
            r.special = 1'b1;
            r.f[3]    = 1'b1;
            res       = res | (emax << mw);
        end else if (az || bz) begin
            r.special = 1'b1;
            r.f[1]    = 1'b1;
        end else begin
            prod = (fa | (one << mw)) * (fb | (one << mw));
            e    = ea + eb - bias;
            if (prod >= (one << (2 * mw + 1))) begin
                shift = mw + 1;
                e     = e + 1;
            end else begin
                shift = mw;
            end
            kept = prod >> shift;
            rem  = prod & ((one << shift) - 1);
            half = one << (shift - 1);
            case (rm)
                0:       up = (rem > half) || ((rem == half) && ((kept & 1) == 1));
                1:       up = 1'b0;
                2:       up = (rem != 0) && !sign;
                default: up = (rem != 0) && sign;
            endcase
            kept = kept + longint'(up);
            if (kept == (one << (mw + 1))) begin
                kept = kept >> 1;
                e    = e + 1;
            end
            if (e >= emax) begin
                to_inf = (rm == 0) || (rm == 2 && !sign) || (rm == 3 && sign);
                r.f[6] = 1'b1;
                r.f[0] = 1'b1;
                r.f[3] = to_inf;
                res    = res | (to_inf ? (emax << mw) : (((emax - 1) << mw) | mask));
            end else if (e <= 0) begin
                r.f[5] = 1'b1;
                r.f[1] = 1'b1;
                r.f[0] = 1'b1;
            end else begin
                r.f[0] = (rem != 0);
                res    = res | (e << mw) | (kept & mask);
            end
        end
        r.p = 32'(res);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input bit wide, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] rm, input int poke_at, output int lat,
                                 output logic [31:0] p_obs, output logic [6:0] f_obs,
                                 output logic busy_obs);
        lat      = -1;
        p_obs    = 'x;
        f_obs    = 'x;
        busy_obs = 1'bx;
        @(negedge clk);
        if (wide) begin
            a32 = a; b32 = b; rm32 = rm; start32 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; rm16 = rm; start16 = 1'b1;
        end
        @(posedge clk);
        #1;
        start32 = 1'b0;
        start16 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) busy_obs = wide ? busy32 : busy16;
            if (wide ? done32 : done16) begin
                lat = c;
                if (wide) begin
                    p_obs = p32;
                    f_obs = {of32, uf32, nan32, inf32, dn32, z32, nx32};
                end else begin
                    p_obs = {16'h0, p16};
                    f_obs = {of16, uf16, nan16, inf16, dn16, z16, nx16};
                end
                break;
            end
            // Start pulse with junk operands while busy must not disturb the operation
            if (c == poke_at) begin
                a16 = ~a[15:0]; b16 = 16'h4400; a32 = ~a; b32 = 32'h40400000;
                if (wide) start32 = 1'b1; else start16 = 1'b1;
            end else if (c == poke_at + 1) begin
                start32 = 1'b0;
                start16 = 1'b0;
            end
        end
    endtask

    task automatic runVector(input bit wide, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] rm, input int poke_at, input string tag);
        ref_res_t    expv;
        int          lat, exp_lat;
        logic [31:0] p_obs;
        logic [6:0]  f_obs;
        logic        busy_obs;
        applyStimulus(wide, a, b, rm, poke_at, lat, p_obs, f_obs, busy_obs);
        expv    = ref_mul(wide ? 8 : 5, wide ? 23 : 10, longint'(a), longint'(b), int'(rm));
        exp_lat = expv.special ? 2 : ((wide ? N32 : N16) + 4);
        vectors++;
        checkOutput({tag, " P"}, p_obs, expv.p);
        checkOutput({tag, " flags"}, 32'(f_obs), 32'(expv.f));
        checkOutput({tag, " done cycle"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " busy"}, 32'(busy_obs), 32'd1);
    endtask

    logic [31:0] ra, rb, held_p;

    initial begin
        rst32_n = 1'b0; rst16_n = 1'b0;
        start32 = 1'b0; start16 = 1'b0;
        rm32 = '0; rm16 = '0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset P32", p32, 32'h0);
        checkOutput("reset ctl32", {30'h0, busy32, done32}, 32'h0);
        checkOutput("reset flags32", {25'h0, of32, uf32, nan32, inf32, dn32, z32, nx32}, 32'h0);
        checkOutput("reset P16", {16'h0, p16}, 32'h0);
        rst32_n = 1'b1;
        rst16_n = 1'b1;
        @(negedge clk);

        runVector(1, 32'h40000000, 32'h40000000, 2'b00, 0, "T1");
        // Start raised in the DONE cycle is ignored
        start32 = 1'b1;
        held_p  = p32;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        checkOutput("T1 start in DONE ignored", 32'(busy32), 32'd0);
        checkOutput("T1 P held", p32, held_p);

        runVector(1, 32'h40f903cc, 32'h40824fcd, 2'b00, 0, "T2a");
        checkOutput("T2a P spec", p32, 32'h41fd831a);
        runVector(1, 32'hb5e81409, 32'h8ea92a2c, 2'b00, 0, "T2b");
        checkOutput("T2b P spec", p32, 32'h05195b75);
        runVector(1, 32'h319a90b8, 32'hffcd3697, 2'b00, 0, "T3a");
        runVector(1, 32'h7f800000, 32'h00000000, 2'b00, 0, "T3b");
        runVector(1, 32'h7f000000, 32'h7f000000, 2'b00, 0, "T4 RNE");
        runVector(1, 32'h7f000000, 32'h7f000000, 2'b01, 0, "T4 RTZ");
        runVector(1, 32'h7f000000, 32'hff000000, 2'b10, 0, "T4 RUP");
        checkOutput("T4 RUP P spec", p32, 32'hff7fffff);
        runVector(1, 32'h7f000000, 32'hff000000, 2'b11, 0, "T4 RDN");
        runVector(1, 32'h00800000, 32'h3f000000, 2'b00, 0, "T5a");
        runVector(1, 32'h00000001, 32'h3f800000, 2'b00, 0, "T5b");
        runVector(1, 32'hff800000, 32'h3f800000, 2'b00, 0, "inf x one");
        runVector(1, 32'h3fffffff, 32'h3fffffff, 2'b10, 0, "round carry");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(3) != 0) ra[30:23] = 8'($urandom_range(215, 40));
            if ($urandom_range(3) != 0) rb[30:23] = 8'($urandom_range(215, 40));
            runVector(1, ra, rb, 2'($urandom_range(3)), 0, $sformatf("rand32 %0d", i));
        end

        runVector(0, 32'h4000, 32'h4000, 2'b00, 0, "T6");
        checkOutput("T6 P spec", {16'h0, p16}, 32'h4400);
        runVector(0, 32'h3e00, 32'hc100, 2'b00, 3, "T6 start while busy");

        // Reset in cycle 5 of an operation aborts it with everything cleared
        @(negedge clk);
        a16 = 16'h4200; b16 = 16'h4200; rm16 = 2'b00; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        rst16_n = 1'b0;
        #1;
        checkOutput("T6 rst ctl", {30'h0, busy16, done16}, 32'h0);
        checkOutput("T6 rst P", {16'h0, p16}, 32'h0);
        checkOutput("T6 rst flags", {25'h0, of16, uf16, nan16, inf16, dn16, z16, nx16}, 32'h0);
        @(negedge clk);
        rst16_n = 1'b1;
        runVector(0, 32'h4200, 32'h4200, 2'b00, 0, "T6 after reset");

        for (int i = 0; i < 12; i++) begin
            ra = {16'h0, 16'($urandom)};
            rb = {16'h0, 16'($urandom)};
            if ($urandom_range(3) != 0) ra[14:10] = 5'($urandom_range(27, 4));
            if ($urandom_range(3) != 0) rb[14:10] = 5'($urandom_range(27, 4));
            runVector(0, ra, rb, 2'($urandom_range(3)), 0, $sformatf("rand16 %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
